// File: rtl/ysyx_25030081_core_seq_pkg.sv
// Shared types and helpers for the RV32I multi-cycle sequencer.
// Holds the state encoding, mem_op bit positions and the alignment check.
package ysyx_25030081_core_seq_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StIfReq,
        StIfWait,
        StExec,
        StLsReq,
        StLsWait,
        StWb,
        StHalt,
        StErr
    } state_e;

    localparam int unsigned MemOpUnsigned = 2;
    localparam int unsigned MemOpWord     = 1;
    localparam int unsigned MemOpHalf     = 0;

    // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0; bytes never trap.
    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        return (op[MemOpWord] && (addr_lo != 2'b00)) || (op[MemOpHalf] && addr_lo[0]);
    endfunction

endpackage

// File: rtl/ysyx_25030081_core_seq_if.sv
// Instruction and data bus handshakes between the sequencer (master) and memory (slave).
interface ysyx_25030081_core_seq_if;

    logic       imem_req_valid;
    logic       imem_req_ready;
    logic       imem_rsp_valid;
    logic       imem_rsp_err;
    logic       imem_rsp_ready;

    logic       dmem_req_valid;
    logic       dmem_req_wen;
    logic [2:0] dmem_req_op;
    logic       dmem_req_ready;
    logic       dmem_rsp_valid;
    logic       dmem_rsp_err;
    logic       dmem_rsp_ready;

    modport master (
        output imem_req_valid, imem_rsp_ready,
        output dmem_req_valid, dmem_req_wen, dmem_req_op, dmem_rsp_ready,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_err,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_err
    );

    modport slave (
        input  imem_req_valid, imem_rsp_ready,
        input  dmem_req_valid, dmem_req_wen, dmem_req_op, dmem_rsp_ready,
        output imem_req_ready, imem_rsp_valid, imem_rsp_err,
        output dmem_req_ready, dmem_rsp_valid, dmem_rsp_err
    );

endinterface

// File: rtl/ysyx_25030081_wdt.sv
// Stall watchdog: counts enabled cycles, clears on request, flags the cycle in which
// the count reaches 2^TIMEOUT_W-1.
module ysyx_25030081_wdt #(
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam logic [TIMEOUT_W-1:0] Limit = '1;

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != Limit)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counting the current stalled cycle brings the total to the limit.
    assign timeout = en && (cnt_q == (Limit - 1'b1));

endmodule

// File: rtl/ysyx_25030081_core_seq.sv
// Multi-cycle fetch/execute/load-store/writeback sequencer with halt, error and watchdog.
// Optional performance counters are built when YSYX_25030081_PERF_EN is defined.
module ysyx_25030081_core_seq
    import ysyx_25030081_core_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    ysyx_25030081_core_seq_if.master   bus,
    output logic                       inst_latch_en,
    input  logic                       dec_reg_wen,
    input  logic                       dec_mem_ren,
    input  logic                       dec_mem_wen,
    input  logic [2:0]                 dec_mem_op,
    input  logic [1:0]                 mem_addr_lo,
    input  logic                       halt_req,
    output logic                       load_latch_en,
    output logic                       reg_wen,
    output logic                       pc_wen,
    output logic                       halted,
    output logic                       err,
    output logic [63:0]                perf_cycle,
    output logic [63:0]                perf_instret
);

    state_e state_q, state_d;
    logic   mem_acc;
    logic   wdt_clr;
    logic   wdt_en;
    logic   wdt_timeout;

    assign mem_acc = dec_mem_ren | dec_mem_wen;
    assign wdt_clr = (state_d != state_q);
    assign wdt_en  = (state_q == StIfReq) || (state_q == StIfWait) ||
                     (state_q == StLsReq) || (state_q == StLsWait);

    ysyx_25030081_wdt #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_wdt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wdt_clr),
        .en      (wdt_en),
        .timeout (wdt_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the two Mealy latch strobes; a completed handshake beats the watchdog.
    always_comb begin
        state_d       = state_q;
        inst_latch_en = 1'b0;
        load_latch_en = 1'b0;
        unique case (state_q)
            StIdle: state_d = StIfReq;
            StIfReq: begin
                if (bus.imem_req_ready) begin
                    state_d = StIfWait;
                end else if (wdt_timeout) begin
                    state_d = StErr;
                end
            end
            StIfWait: begin
                if (bus.imem_rsp_valid) begin
                    if (bus.imem_rsp_err) begin
                        state_d = StErr;
                    end else begin
                        inst_latch_en = 1'b1;
                        state_d       = StExec;
                    end
                end else if (wdt_timeout) begin
                    state_d = StErr;
                end
            end
            StExec: begin
                if (halt_req) begin
                    state_d = StHalt;
                end else if (mem_acc && misaligned(dec_mem_op, mem_addr_lo)) begin
                    state_d = StErr;
                end else if (mem_acc) begin
                    state_d = StLsReq;
                end else begin
                    state_d = StWb;
                end
            end
            StLsReq: begin
                if (bus.dmem_req_ready) begin
                    state_d = StLsWait;
                end else if (wdt_timeout) begin
                    state_d = StErr;
                end
            end
            StLsWait: begin
                if (bus.dmem_rsp_valid) begin
                    if (bus.dmem_rsp_err) begin
                        state_d = StErr;
                    end else begin
                        load_latch_en = dec_mem_ren;
                        state_d       = StWb;
                    end
                end else if (wdt_timeout) begin
                    state_d = StErr;
                end
            end
            StWb:   state_d = StIfReq;
            StHalt: state_d = StHalt;
            StErr:  state_d = StErr;
            default: state_d = StErr;
        endcase
    end

    always_comb begin
        bus.imem_req_valid = 1'b0;
        bus.imem_rsp_ready = 1'b0;
        bus.dmem_req_valid = 1'b0;
        bus.dmem_req_wen   = 1'b0;
        bus.dmem_req_op    = 3'b000;
        bus.dmem_rsp_ready = 1'b0;
        reg_wen            = 1'b0;
        pc_wen             = 1'b0;
        halted             = 1'b0;
        err                = 1'b0;
        unique case (state_q)
            StIfReq:  bus.imem_req_valid = 1'b1;
            StIfWait: bus.imem_rsp_ready = 1'b1;
            StLsReq: begin
                bus.dmem_req_valid = 1'b1;
                bus.dmem_req_wen   = dec_mem_wen;
                bus.dmem_req_op    = dec_mem_op;
            end
            StLsWait: bus.dmem_rsp_ready = 1'b1;
            StWb: begin
                reg_wen = dec_reg_wen;
                pc_wen  = 1'b1;
            end
            StHalt: halted = 1'b1;
            StErr:  err    = 1'b1;
            default: ;
        endcase
    end

`ifdef YSYX_25030081_PERF_EN
    logic [63:0] perf_cycle_q;
    logic [63:0] perf_instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycle_q   <= '0;
            perf_instret_q <= '0;
        end else begin
            if ((state_q != StHalt) && (state_q != StErr)) begin
                perf_cycle_q <= perf_cycle_q + 64'd1;
            end
            if (state_q == StWb) begin
                perf_instret_q <= perf_instret_q + 64'd1;
            end
        end
    end

    assign perf_cycle   = perf_cycle_q;
    assign perf_instret = perf_instret_q;
`else
    assign perf_cycle   = '0;
    assign perf_instret = '0;
`endif

endmodule

// File: doc/ysyx_25030081_core_seq.md
Name: ysyx_25030081_core_seq

Overview:
Multi-cycle sequencer for the RV32I core: fetch, execute, load/store, writeback. Drives valid/ready handshakes to the instruction and data buses. Gates the decoder's raw reg_wen/mem_ren/mem_wen/mem_op into single-cycle commit strobes. Sits between the control unit outputs, the register file/PC write ports and the bus interfaces. Provides halt, error and watchdog handling.

Parameters:
TIMEOUT_W, 8, watchdog counter width; legal range 2..16; timeout fires at 2^TIMEOUT_W-1 stalled cycles.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  fetch request accepted
imem_rsp_valid  in  1  fetch response valid
imem_rsp_err  in  1  fetch bus error, qualified by imem_rsp_valid
imem_rsp_ready  out  1  fetch response accepted
inst_latch_en  out  1  load instruction register
dec_reg_wen  in  1  decoder register-write request
dec_mem_ren  in  1  decoder load
dec_mem_wen  in  1  decoder store
dec_mem_op  in  3  [2]=unsigned, [1]=word, [0]=half, 00=byte
mem_addr_lo  in  2  ALU result bits [1:0] (effective address)
halt_req  in  1  ebreak decoded
dmem_req_valid  out  1  data request valid
dmem_req_wen  out  1  1=store, 0=load
dmem_req_op  out  3  copy of dec_mem_op
dmem_req_ready  in  1  data request accepted
dmem_rsp_valid  in  1  data response/ack valid
dmem_rsp_err  in  1  data bus error, qualified by dmem_rsp_valid
dmem_rsp_ready  out  1  data response accepted
load_latch_en  out  1  capture load data
reg_wen  out  1  register-file commit strobe
pc_wen  out  1  PC update strobe
halted  out  1  sticky halt
err  out  1  sticky error
perf_cycle  out  64  cycle count (optional feature)
perf_instret  out  64  retired-instruction count (optional feature)

Behaviour:
- States: IDLE, IF_REQ, IF_WAIT, EXEC, LS_REQ, LS_WAIT, WB, HALT, ERR. Binary-encoded state register.
- Reset (async, rst_n=0): state=IDLE, watchdog=0, all outputs 0. Reset asserted mid-transaction drops every valid/ready immediately. No transaction is resumed after reset.
- IDLE -> IF_REQ unconditionally on the next clk.
- IF_REQ: imem_req_valid=1, held until imem_req_ready. Valid never drops early. On ready -> IF_WAIT.
- IF_WAIT: imem_rsp_ready=1.
  - rsp_valid and !rsp_err: inst_latch_en=1 in the same cycle (Mealy), -> EXEC.
  - rsp_valid and rsp_err: -> ERR, no latch pulse.
- EXEC: decoder outputs are stable. Priority, highest first:
  - halt_req -> HALT (no memory access, no commit).
  - Misaligned access (word with mem_addr_lo!=0, or half with mem_addr_lo[0]=1) when mem_ren|mem_wen -> ERR.
  - mem_ren|mem_wen -> LS_REQ.
  - Otherwise -> WB.
- LS_REQ: dmem_req_valid=1. dmem_req_wen=dec_mem_wen. dmem_req_op=dec_mem_op. These are held stable until dmem_req_ready, then -> LS_WAIT.
- LS_WAIT: dmem_rsp_ready=1.
  - rsp_valid and !err: load_latch_en=dec_mem_ren, -> WB.
  - rsp_valid and err: -> ERR. A store's bus error also gives ERR.
- WB: reg_wen=dec_reg_wen, pc_wen=1, both for exactly 1 cycle, -> IF_REQ.
- HALT: halted=1. ERR: err=1. Both are absorbing until reset. No bus activity in either.
- Latency with zero-wait buses: non-memory instruction 4 cycles; load/store 6 cycles.
- Watchdog:
  - Counter clears on every state change.
  - Increments each cycle spent in IF_REQ, IF_WAIT, LS_REQ or LS_WAIT.
  - Reaching 2^TIMEOUT_W-1 forces -> ERR next cycle, unless a handshake completes in that same cycle (handshake wins).
- All outputs except inst_latch_en and load_latch_en are pure functions of state.

Optional Feature:
- YSYX_25030081_PERF_EN defined:
  - perf_cycle increments every cycle after reset, except in HALT/ERR.
  - perf_instret increments on each WB cycle.
  - Both are 64-bit, reset to 0, wrap modulo 2^64.
- Undefined: the ports remain, tied to 0; no counter flops are synthesized.

Decomposition:
- Shared `include header holds:
  - state encoding localparams;
  - mem_op bit positions (UNSIGNED=2, WORD=1, HALF=0);
  - the alignment-check macro.
- One natural sub-module: ysyx_25030081_wdt (clear/enable/width-parameterised counter, timeout output).

Test Plan:
- Zero-wait buses, addi then add -> pc_wen pulses at cycles 4 and 8 after IDLE exit; reg_wen=1 on each WB.
- lw with mem_addr_lo=0, dmem_req_ready delayed 3 cycles -> dmem_req_valid held 4 cycles, op=010, load_latch_en 1 cycle, retire at cycle 9.
- sh with mem_addr_lo=01 -> ERR from EXEC, dmem_req_valid never asserted, err=1 sticky.
- halt_req=1 together with dec_mem_wen=1 in EXEC -> HALT, no dmem request, halted=1, pc_wen stays 0.
- TIMEOUT_W=2, imem_req_ready held 0 -> err=1 after 3 stalled cycles in IF_REQ.
- rst_n pulsed low during LS_WAIT -> all valid/ready outputs 0 asynchronously; after release IDLE -> IF_REQ; perf counters (PERF_EN) read 0.
